// File: rtl/int_to_float_encoder_pkg.sv
// Shared float-format field positions and status codes used by the encoder and the adder.
`default_nettype none
package int_to_float_encoder_pkg;
  localparam int SIGN_BIT = 0;
  localparam int EXP_MSB  = 1;
  localparam int EXP_LSB  = 6;
  localparam int FRAC_MSB = 7;
  localparam int FRAC_LSB = 31;
  localparam int EXP_BIAS = 31;

  typedef enum logic [3:0] {
    ST_EXACT     = 4'd0,
    ST_OVERFLOW  = 4'd1,
    ST_UNDERFLOW = 4'd2,
    ST_INEXACT   = 4'd3
  } status_e;
endpackage
`default_nettype wire

// File: rtl/int_to_float_encoder.sv
// Iterative int32 -> custom float32 converter: one normalising left shift per cycle,
// truncating fraction packing, adder-compatible status codes.
`default_nettype none
module int_to_float_encoder #(
  parameter int EXP_BIAS = 31,
  parameter int INT_W    = 32
) (
  input  logic          clock_100kHz,
  input  logic          reset,
  input  logic [31:0]   int_in,
  input  logic          start,
  output logic [0:31]   data_out,
  output logic [3:0]    status_out,
  output logic          busy,
  output logic          done
);
  import int_to_float_encoder_pkg::SIGN_BIT;
  import int_to_float_encoder_pkg::EXP_MSB;
  import int_to_float_encoder_pkg::EXP_LSB;
  import int_to_float_encoder_pkg::FRAC_MSB;
  import int_to_float_encoder_pkg::FRAC_LSB;
  import int_to_float_encoder_pkg::ST_EXACT;
  import int_to_float_encoder_pkg::ST_INEXACT;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_NORMALIZE = 2'd2,
    S_PACK      = 2'd3
  } state_e;

  // Exponent of a value whose leading 1 sits in the MSB of the 32-bit magnitude.
  localparam logic [5:0] EXP_INIT = 6'(EXP_BIAS + INT_W - 1);

  state_e      state;
  logic [31:0] mag;
  logic [5:0]  exp;
  logic        sign;

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      mag        <= 32'd0;
      exp        <= 6'd0;
      sign       <= 1'b0;
      data_out   <= 32'd0;
      status_out <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mag   <= int_in;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Two's-complement negate also maps -2^31 onto 0x80000000 unchanged.
          sign  <= mag[31];
          mag   <= mag[31] ? (~mag + 32'd1) : mag;
          exp   <= EXP_INIT;
          state <= (mag == 32'd0) ? S_PACK : S_NORMALIZE;
        end
        S_NORMALIZE: begin
          if (!mag[31]) begin
            mag <= mag << 1;
            exp <= exp - 6'd1;
          end else begin
            state <= S_PACK;
          end
        end
        S_PACK: begin
          if (mag == 32'd0) begin
            data_out   <= 32'd0;
            status_out <= ST_EXACT;
          end else begin
            data_out[SIGN_BIT]          <= sign;
            data_out[EXP_MSB:EXP_LSB]   <= exp;
            data_out[FRAC_MSB:FRAC_LSB] <= mag[30:6];
            status_out <= (|mag[5:0]) ? ST_INEXACT : ST_EXACT;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_int_to_float_encoder.sv
// Directed self-checking bench for int_to_float_encoder.
`default_nettype none
module tb_int_to_float_encoder;
  logic        clk;
  logic        rst_n;
  logic [31:0] int_in;
  logic        start;
  logic [0:31] data_out;
  logic [3:0]  status_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int_to_float_encoder dut (
    .clock_100kHz (clk),
    .reset        (rst_n),
    .int_in       (int_in),
    .start        (start),
    .data_out     (data_out),
    .status_out   (status_out),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Accept on edge 0, then count edges until done is seen.
  task automatic run(input string tag, input logic [31:0] v, input logic [31:0] exp_d,
                     input logic [3:0] exp_s, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    int_in = v;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    while (!done && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_data"}, data_out, exp_d);
    chk({tag, "_status"}, 32'(status_out), 32'(exp_s));
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  n;
    logic saw_done;
    rst_n  = 1'b0;
    start  = 1'b0;
    int_in = 32'd0;
    #1;
    chk("rst_data", data_out, 32'd0);
    chk("rst_status", 32'(status_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("one", 32'h0000_0001, 32'h3E00_0000, 4'd0, 34);
    @(negedge clk);
    chk("one_done_pulse", 32'(done), 32'd0);
    run("three", 32'h0000_0003, 32'h4100_0000, 4'd0, 33);
    run("minint", 32'h8000_0000, 32'hFC00_0000, 4'd0, 3);
    run("maxint", 32'h7FFF_FFFF, 32'h7BFF_FFFF, 4'd3, 4);
    run("bit25", 32'h0200_0000, 32'h7000_0000, 4'd0, 9);

    // Zero input with a start pulse during busy that must be ignored.
    @(negedge clk);
    int_in = 32'd0;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    int_in = 32'h0000_0005;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("zero_latency", 32'(n), 32'd2);
    chk("zero_data", data_out, 32'd0);
    chk("zero_status", 32'(status_out), 32'd0);
    @(negedge clk);
    chk("zero_no_reaccept", 32'(busy), 32'd0);

    // Reset in the middle of normalisation of int_in=1.
    @(negedge clk);
    int_in = 32'h0000_0001;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_data", data_out, 32'd0);
    chk("abort_status", 32'(status_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    run("minus1", 32'hFFFF_FFFF, 32'hBE00_0000, 4'd0, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
